// File: rtl/piece_gen.sv
// Piece ID generator: seedable Galois LFSR feeding a bag randomizer, buffered
// in a head + preview queue that the game controller drains with a take strobe.
module piece_gen #(
  parameter int                NUM_PIECES    = 7,
  parameter int                PIECE_W       = 3,
  parameter int                LFSR_W        = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
  parameter int                PREVIEW_DEPTH = 3,
  parameter int                MAX_TRIES     = 4,
  parameter int                WARMUP        = 8
) (
  input  logic                                 clka,
  input  logic                                 restart,
  input  logic                                 seed_load,
  input  logic [LFSR_W-1:0]                    seed_in,
  input  logic                                 user_evt,
  input  logic                                 take,
  output logic [PIECE_W-1:0]                   piece,
  output logic                                 piece_valid,
  output logic [PREVIEW_DEPTH*PIECE_W-1:0]     preview,
  output logic [$clog2(PREVIEW_DEPTH+2)-1:0]   q_count,
  output logic [NUM_PIECES-1:0]                bag_mask
);

  localparam int Q  = PREVIEW_DEPTH + 1;
  localparam int CW = $clog2(Q + 1);
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  typedef enum logic [1:0] {WARM = 2'd0, FILL = 2'd1, FULL = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [LFSR_W-1:0]    lfsr_q, lfsr_d, lfsr_nxt;
  logic [NUM_PIECES-1:0] bag_q, bag_d;
  logic [TW-1:0]        tries_q, tries_d;
  logic [WW-1:0]        warm_q, warm_d;
  logic [PIECE_W-1:0]   qmem_q [Q];
  logic [PIECE_W-1:0]   qmem_d [Q];
  logic [CW-1:0]        cnt_q, cnt_d, tail;
  logic [PIECE_W-1:0]   cand, low_idx, push_val;
  logic                 cand_ok, draw_en, push, pop;

  always_comb begin
    lfsr_nxt = '0;
    lfsr_d   = lfsr_q;
    if (seed_load) begin
      lfsr_nxt = seed_in;
    end else begin
      lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
      if (user_evt) lfsr_nxt[0] = ~lfsr_nxt[0];
      else          lfsr_nxt[0] = lfsr_nxt[0];
    end
    // an all-zero Galois state would lock up
    if (lfsr_nxt == '0) lfsr_d = LFSR_W'(1);
    else                lfsr_d = lfsr_nxt;
  end

  always_comb begin
    cand     = lfsr_q[PIECE_W-1:0];
    cand_ok  = 1'b0;
    low_idx  = '0;
    push     = 1'b0;
    push_val = cand;
    tries_d  = tries_q;
    bag_d    = bag_q;
    pop      = take && (cnt_q != '0);
    draw_en  = (state_q == FILL) && (cnt_q < CW'(Q));
    for (int i = 0; i < NUM_PIECES; i++) begin
      if ((cand == PIECE_W'(i)) && bag_q[i]) cand_ok = 1'b1;
    end
    for (int i = NUM_PIECES - 1; i >= 0; i--) begin
      if (bag_q[i]) low_idx = PIECE_W'(i);
    end
    if (draw_en) begin
      if (cand_ok) begin
        push    = 1'b1;
        tries_d = '0;
      end else if (int'(tries_q) == MAX_TRIES - 1) begin
        push     = 1'b1;
        push_val = low_idx;
        tries_d  = '0;
      end else begin
        tries_d = tries_q + TW'(1);
      end
    end else begin
      tries_d = tries_q;
    end
    if (push) begin
      for (int i = 0; i < NUM_PIECES; i++) begin
        if (push_val == PIECE_W'(i)) bag_d[i] = 1'b0;
      end
    end else begin
      bag_d = bag_q;
    end
    // last piece of the bag drawn: start a fresh bag on the same edge
    if (bag_d == '0) bag_d = '1;
    else             bag_d = bag_d;
  end

  always_comb begin
    qmem_d = qmem_q;
    tail   = pop ? (cnt_q - CW'(1)) : cnt_q;
    if (pop) begin
      for (int i = 0; i < Q - 1; i++) qmem_d[i] = qmem_q[i+1];
      qmem_d[Q-1] = '0;
    end else begin
      qmem_d = qmem_q;
    end
    if (push) begin
      for (int i = 0; i < Q; i++) begin
        if (tail == CW'(i)) qmem_d[i] = push_val;
      end
    end else begin
      qmem_d = qmem_d;
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    case (state_q)
      WARM: begin
        if (int'(warm_q) + 1 >= WARMUP) state_d = FILL;
        else                            warm_d  = warm_q + WW'(1);
      end
      FILL: begin
        if (push && !pop && (int'(cnt_q) == Q - 1)) state_d = FULL;
        else                                        state_d = FILL;
      end
      FULL: begin
        if (pop) state_d = FILL;
        else     state_d = FULL;
      end
      default: state_d = WARM;
    endcase
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      state_q <= WARM;
      lfsr_q  <= SEED_EFF;
      bag_q   <= '1;
      tries_q <= '0;
      warm_q  <= '0;
      cnt_q   <= '0;
      qmem_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      bag_q   <= bag_d;
      tries_q <= tries_d;
      warm_q  <= warm_d;
      cnt_q   <= cnt_d;
      qmem_q  <= qmem_d;
    end
  end

  // queue slots past the occupancy are held at zero, so preview needs no masking
  always_comb begin
    preview = '0;
    for (int i = 0; i < PREVIEW_DEPTH; i++) preview[i*PIECE_W +: PIECE_W] = qmem_q[i+1];
  end

  assign piece       = qmem_q[0];
  assign piece_valid = (cnt_q != '0);
  assign q_count     = cnt_q;
  assign bag_mask    = bag_q;

endmodule

// File: tb/tb_piece_gen.sv
// Scoreboard bench for piece_gen: hand-derived directed timeline, stream runs
// for the bag property and seeding determinism, and a fallback-path instance.
module tb_piece_gen;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic        restart_a, seed_load_a, user_evt_a, take_a;
  logic [15:0] seed_in_a;
  logic [2:0]  piece_a;
  logic        piece_valid_a;
  logic [8:0]  preview_a;
  logic [2:0]  q_count_a;
  logic [6:0]  bag_mask_a;

  logic        restart_b, seed_load_b, user_evt_b, take_b;
  logic [15:0] seed_in_b;
  logic [2:0]  piece_b;
  logic        piece_valid_b;
  logic [8:0]  preview_b;
  logic [2:0]  q_count_b;
  logic [4:0]  bag_mask_b;

  piece_gen dut_a (
    .clka(clka), .restart(restart_a), .seed_load(seed_load_a), .seed_in(seed_in_a),
    .user_evt(user_evt_a), .take(take_a), .piece(piece_a), .piece_valid(piece_valid_a),
    .preview(preview_a), .q_count(q_count_a), .bag_mask(bag_mask_a)
  );

  piece_gen #(.NUM_PIECES(5), .MAX_TRIES(1), .WARMUP(0)) dut_b (
    .clka(clka), .restart(restart_b), .seed_load(seed_load_b), .seed_in(seed_in_b),
    .user_evt(user_evt_b), .take(take_b), .piece(piece_b), .piece_valid(piece_valid_b),
    .preview(preview_b), .q_count(q_count_b), .bag_mask(bag_mask_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int sb[$];
  int rec [0:699];
  int seq1 [0:699];
  int rec_n = 0;
  bit rec_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Monitor: every accepted take of dut_a is scored against the expected queue.
  always @(negedge clka) begin
    if (take_a && piece_valid_a && !restart_a) begin
      if (sb.size() > 0) chk("pop_piece", int'(piece_a), sb.pop_front());
      if (rec_en) begin
        if (rec_n < 700) rec[rec_n] = int'(piece_a);
        rec_n++;
      end
    end
  end

  task automatic cyc_a(input logic tk, input logic sl, input logic [15:0] si, input logic ue);
    take_a = tk; seed_load_a = sl; seed_in_a = si; user_evt_a = ue;
    @(posedge clka); #1;
  endtask

  task automatic cyc_b(input logic tk, input logic sl, input logic [15:0] si, input logic ue);
    take_b = tk; seed_load_b = sl; seed_in_b = si; user_evt_b = ue;
    @(posedge clka); #1;
  endtask

  task automatic take_exp(input int v, input logic sl, input logic [15:0] si);
    sb.push_back(v);
    cyc_a(1'b1, sl, si, 1'b0);
  endtask

  task automatic bag_check(input string name);
    for (int g = 0; g < 100; g++) begin
      logic [7:0] mask;
      bit ok;
      mask = '0;
      ok = 1'b1;
      for (int k = 0; k < 7; k++) begin
        int v;
        v = rec[g*7 + k];
        if (v > 6 || mask[v]) ok = 1'b0;
        else mask[v] = 1'b1;
      end
      chk(name, int'(ok && (mask == 8'h7F)), 1);
    end
  endtask

  task automatic stream_run(input bit use_evt);
    bit seen_valid;
    restart_a = 1'b1;
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
    restart_a = 1'b0;
    rec_n = 0;
    rec_en = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 6000 && rec_n < 700; c++) begin
      cyc_a(1'b1, 1'b0, 16'h0000, use_evt ? c[0] : 1'b0);
      if (c < 8) seen_valid = seen_valid | piece_valid_a | (q_count_a != 3'd0);
      if (c == 7) chk("warm_no_output", int'(seen_valid), 0);
      if (c == 8 && !use_evt) chk("first_valid_edge9", int'(piece_valid_a), 1);
    end
    take_a = 1'b0;
    rec_en = 1'b0;
    chk("stream_pieces", rec_n, 700);
  endtask

  initial begin
    int ndiff;
    restart_a = 1'b1; seed_load_a = 1'b0; seed_in_a = 16'h0000; user_evt_a = 1'b0; take_a = 1'b0;
    restart_b = 1'b1; seed_load_b = 1'b0; seed_in_b = 16'h0000; user_evt_b = 1'b0; take_b = 1'b0;

    // directed timeline on default parameters
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("rst_piece", int'(piece_a), 0);
    chk("rst_valid", int'(piece_valid_a), 0);
    chk("rst_preview", int'(preview_a), 0);
    chk("rst_q", int'(q_count_a), 0);
    chk("rst_bag", int'(bag_mask_a), 7'h7F);
    restart_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
      chk("warm_q", int'(q_count_a), 0);
    end
    for (int k = 0; k < 4; k++) begin
      cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
      chk("fill_q", int'(q_count_a), k + 1);
    end
    chk("full_piece", int'(piece_a), 4);
    chk("full_preview", int'(preview_a), 9'h00A);
    chk("full_bag", int'(bag_mask_a), 7'h68);
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("full_hold_q", int'(q_count_a), 4);
    chk("full_hold_bag", int'(bag_mask_a), 7'h68);
    take_exp(4, 1'b0, 16'h0000);
    chk("pop_full_q", int'(q_count_a), 3);
    chk("pop_full_piece", int'(piece_a), 2);
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("refill_q", int'(q_count_a), 4);
    chk("refill_bag", int'(bag_mask_a), 7'h60);
    chk("refill_preview", int'(preview_a), 9'h0C1);
    take_exp(2, 1'b0, 16'h0000);
    chk("drain_q3", int'(q_count_a), 3);
    take_exp(1, 1'b1, 16'h0005);
    chk("reject_q2", int'(q_count_a), 2);
    take_exp(0, 1'b1, 16'h0006);
    chk("simul_q", int'(q_count_a), 2);
    chk("simul_piece", int'(piece_a), 3);
    chk("simul_preview", int'(preview_a), 9'h005);
    chk("simul_bag", int'(bag_mask_a), 7'h40);
    cyc_a(1'b0, 1'b1, 16'h0000, 1'b0);
    chk("bag_reload", int'(bag_mask_a), 7'h7F);
    chk("reload_q", int'(q_count_a), 3);
    chk("reload_preview", int'(preview_a), 9'h035);
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("seed0_q", int'(q_count_a), 4);
    chk("seed0_bag", int'(bag_mask_a), 7'h7D);
    chk("seed0_preview", int'(preview_a), 9'h075);
    take_exp(3, 1'b1, 16'h0002);
    chk("no_push_at_full_q", int'(q_count_a), 3);
    chk("no_push_preview", int'(preview_a), 9'h00E);
    cyc_a(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("repush_q", int'(q_count_a), 4);
    chk("repush_bag", int'(bag_mask_a), 7'h79);
    chk("repush_preview", int'(preview_a), 9'h08E);
    take_exp(5, 1'b0, 16'h0000);
    chk("pre_rst_q", int'(q_count_a), 3);
    restart_a = 1'b1;
    cyc_a(1'b0, 1'b1, 16'h1234, 1'b1);
    chk("midrst_q", int'(q_count_a), 0);
    chk("midrst_bag", int'(bag_mask_a), 7'h7F);
    chk("midrst_valid", int'(piece_valid_a), 0);
    chk("midrst_piece", int'(piece_a), 0);
    chk("midrst_preview", int'(preview_a), 0);
    chk("directed_sb_drained", sb.size(), 0);

    // stream run 1: first four pops are hand-derived, rest checked as bags
    sb.push_back(4); sb.push_back(2); sb.push_back(1); sb.push_back(0);
    stream_run(1'b0);
    chk("run1_sb_drained", sb.size(), 0);
    bag_check("run1_bag_perm");
    for (int i = 0; i < 700; i++) seq1[i] = rec[i];

    // stream run 2: same seed timing, expects run 1's sequence verbatim
    for (int i = 0; i < 700; i++) sb.push_back(seq1[i]);
    stream_run(1'b0);
    chk("run2_sb_drained", sb.size(), 0);
    sb.delete();

    // stream run 3: user_evt toggling must change the sequence yet keep bags
    stream_run(1'b1);
    bag_check("run3_bag_perm");
    ndiff = 0;
    for (int i = 0; i < 700; i++) if (rec[i] != seq1[i]) ndiff++;
    chk("evt_diverges", int'(ndiff > 0), 1);

    // fallback path: NUM_PIECES=5, MAX_TRIES=1, candidate pinned at 7
    cyc_b(1'b0, 1'b0, 16'h0000, 1'b0);
    cyc_b(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("b_rst_q", int'(q_count_b), 0);
    chk("b_rst_bag", int'(bag_mask_b), 5'h1F);
    chk("b_rst_valid", int'(piece_valid_b), 0);
    restart_b = 1'b0;
    cyc_b(1'b0, 1'b1, 16'h0007, 1'b1);
    chk("b_warm0_q", int'(q_count_b), 0);
    cyc_b(1'b0, 1'b1, 16'h0007, 1'b0);
    chk("b_fb_q", int'(q_count_b), 1);
    chk("b_fb_piece", int'(piece_b), 0);
    chk("b_fb_bag", int'(bag_mask_b), 5'h1E);
    cyc_b(1'b0, 1'b1, 16'h0007, 1'b0);
    chk("b_fb2_preview", int'(preview_b), 9'h001);
    chk("b_fb2_bag", int'(bag_mask_b), 5'h1C);
    cyc_b(1'b0, 1'b1, 16'h0007, 1'b0);
    chk("b_fb3_bag", int'(bag_mask_b), 5'h18);
    cyc_b(1'b0, 1'b1, 16'h0007, 1'b0);
    chk("b_full_q", int'(q_count_b), 4);
    chk("b_full_bag", int'(bag_mask_b), 5'h10);
    cyc_b(1'b1, 1'b1, 16'h0007, 1'b0);
    chk("b_pop_q", int'(q_count_b), 3);
    chk("b_pop_piece", int'(piece_b), 1);
    cyc_b(1'b0, 1'b1, 16'h0007, 1'b0);
    chk("b_reload_q", int'(q_count_b), 4);
    chk("b_reload_bag", int'(bag_mask_b), 5'h1F);
    chk("b_reload_preview", int'(preview_b), 9'h11A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
